// File: rtl/freq_meter_if.sv
// Monitor bus between a divided-clock source and the frequency meter.
// The master drives the measured signal and observes the results; the slave is the meter.
interface freq_meter_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             stalled;
    logic [7:0]       unlock_cnt;

    modport master (
        output sig_in,
        input  period,
        input  high_time,
        input  meas_valid,
        input  locked,
        input  stalled,
        input  unlock_cnt
    );

    modport slave (
        input  sig_in,
        output period,
        output high_time,
        output meas_valid,
        output locked,
        output stalled,
        output unlock_cnt
    );
endinterface

// File: rtl/freq_meter.sv
// Period / high-time meter for a divided clock, with lock and stall detection.
// Counts system-clock cycles between synchronised rising edges of bus.sig_in.
module freq_meter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EXP_PERIOD = 25,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic          clk,
    input  logic          rst,
    freq_meter_if.slave   bus
);

    localparam int unsigned MC_W   = $clog2(LOCK_N + 1);
    localparam int unsigned LO_LIM = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
    localparam int unsigned HI_LIM = EXP_PERIOD + TOL;

    localparam logic [0:0] SEEK = 1'b0;
    localparam logic [0:0] MEAS = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   LO_V      = (CNT_W+1)'(LO_LIM);
    localparam logic [CNT_W:0]   HI_V      = (CNT_W+1)'(HI_LIM);
    localparam logic [MC_W-1:0]  LOCK_V    = MC_W'(LOCK_N);

    logic             s1_q, s2_q, d_q;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             mv_q, mv_d;
    logic             locked_q, locked_d;
    logic             stalled_q, stalled_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [7:0]       unlock_q, unlock_d;

    logic             rise_c;
    logic             match_c;
    logic             drop_c;
    logic [CNT_W:0]   cnt_ext_c;

    assign rise_c    = s2_q & ~d_q;
    assign cnt_ext_c = {1'b0, cnt_q};
    // Widened compare so a low bound near zero cannot wrap.
    assign match_c   = (cnt_ext_c >= LO_V) && (cnt_ext_c <= HI_V);

    // Next-state and measurement logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        hcnt_d    = (s2_q && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_W'(1) : hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        mv_d      = 1'b0;
        locked_d  = locked_q;
        stalled_d = stalled_q;
        match_d   = match_q;
        unlock_d  = unlock_q;
        drop_c    = 1'b0;

        if (rise_c) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end

        case (state_q)
            SEEK: begin
                if (rise_c) begin
                    state_d   = MEAS;
                    stalled_d = 1'b0;
                end
            end
            MEAS: begin
                // A rise coinciding with the timeout count is still a valid edge.
                if (rise_c) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    mv_d     = 1'b1;
                    if (match_c) begin
                        match_d  = (match_q == LOCK_V) ? match_q : match_q + MC_W'(1);
                        locked_d = (match_d == LOCK_V);
                    end else begin
                        match_d  = '0;
                        locked_d = 1'b0;
                        drop_c   = locked_q;
                    end
                end else if (cnt_q == TIMEOUT_V) begin
                    state_d   = SEEK;
                    stalled_d = 1'b1;
                    match_d   = '0;
                    locked_d  = 1'b0;
                    drop_c    = locked_q;
                end
            end
            default: begin
                state_d = SEEK;
            end
        endcase

        if (drop_c && (unlock_q != 8'hFF)) begin
            unlock_d = unlock_q + 8'd1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            d_q       <= 1'b0;
            state_q   <= SEEK;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            mv_q      <= 1'b0;
            locked_q  <= 1'b0;
            stalled_q <= 1'b0;
            match_q   <= '0;
            unlock_q  <= '0;
        end else begin
            s1_q      <= bus.sig_in;
            s2_q      <= s1_q;
            d_q       <= s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            mv_q      <= mv_d;
            locked_q  <= locked_d;
            stalled_q <= stalled_d;
            match_q   <= match_d;
            unlock_q  <= unlock_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.meas_valid = mv_q;
    assign bus.locked     = locked_q;
    assign bus.stalled    = stalled_q;
    assign bus.unlock_cnt = unlock_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a table of sig_in periods with the measurement
// reported at the start of each, plus stall, coincident-timeout, reset and saturation sequences.
module tb_freq_meter;

    localparam int unsigned CNT_W = 16;
    localparam int NVEC = 19;

    typedef struct {
        int per;
        int high;
        int exp_mv;
        int exp_per;
        int exp_high;
        int exp_lk;
        int exp_unl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    freq_meter_if #(.CNT_W(CNT_W)) bus ();

    freq_meter #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (25),
        .TOL        (1),
        .LOCK_N     (4),
        .TIMEOUT    (1023)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int snap_mv, snap_per, snap_high, snap_lk, snap_st, snap_unl, snap_mv_next;

    vec_t tab [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One sig_in period starting with a rising edge; snapshots the outputs
    // right after the register update caused by that edge.
    task automatic run_period(input int per, input int high);
        for (int i = 0; i < per; i++) begin
            bus.sig_in = (i < high);
            @(posedge clk);
            #1;
            if (i == 2) begin
                snap_mv   = int'(bus.meas_valid);
                snap_per  = int'(bus.period);
                snap_high = int'(bus.high_time);
                snap_lk   = int'(bus.locked);
                snap_st   = int'(bus.stalled);
                snap_unl  = int'(bus.unlock_cnt);
            end
            if (i == 3) snap_mv_next = int'(bus.meas_valid);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".period"},     int'(bus.period),     0);
        chk({tag, ".high_time"},  int'(bus.high_time),  0);
        chk({tag, ".meas_valid"}, int'(bus.meas_valid), 0);
        chk({tag, ".locked"},     int'(bus.locked),     0);
        chk({tag, ".stalled"},    int'(bus.stalled),    0);
        chk({tag, ".unlock_cnt"}, int'(bus.unlock_cnt), 0);
    endtask

    initial begin
        // {period, high} driven | what the rise starting it reports (previous period)
        tab[0]  = '{25, 13, 0,  0,  0, 0, 0};
        tab[1]  = '{25, 13, 1, 25, 13, 0, 0};
        tab[2]  = '{25, 13, 1, 25, 13, 0, 0};
        tab[3]  = '{25, 13, 1, 25, 13, 0, 0};
        tab[4]  = '{25, 13, 1, 25, 13, 1, 0};
        tab[5]  = '{27, 13, 1, 25, 13, 1, 0};
        tab[6]  = '{25, 13, 1, 27, 13, 0, 1};
        tab[7]  = '{25, 13, 1, 25, 13, 0, 1};
        tab[8]  = '{25, 13, 1, 25, 13, 0, 1};
        tab[9]  = '{25, 13, 1, 25, 13, 0, 1};
        tab[10] = '{25,  1, 1, 25, 13, 1, 1};
        tab[11] = '{24,  1, 1, 25,  1, 1, 1};
        tab[12] = '{26, 12, 1, 24,  1, 1, 1};
        tab[13] = '{23,  5, 1, 26, 12, 1, 1};
        tab[14] = '{25, 13, 1, 23,  5, 0, 2};
        tab[15] = '{25, 13, 1, 25, 13, 0, 2};
        tab[16] = '{25, 13, 1, 25, 13, 0, 2};
        tab[17] = '{25, 13, 1, 25, 13, 0, 2};
        tab[18] = '{25, 13, 1, 25, 13, 1, 2};

        rst = 1'b1;
        bus.sig_in = 1'b0;
        wait_cycles(3);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < NVEC; v++) begin
            run_period(tab[v].per, tab[v].high);
            chk($sformatf("vec%0d.meas_valid", v), snap_mv, tab[v].exp_mv);
            chk($sformatf("vec%0d.period", v),     snap_per, tab[v].exp_per);
            chk($sformatf("vec%0d.high_time", v),  snap_high, tab[v].exp_high);
            chk($sformatf("vec%0d.locked", v),     snap_lk, tab[v].exp_lk);
            chk($sformatf("vec%0d.unlock_cnt", v), snap_unl, tab[v].exp_unl);
            chk($sformatf("vec%0d.stalled", v),    snap_st, 0);
            if (tab[v].exp_mv == 1) chk($sformatf("vec%0d.pulse_len", v), snap_mv_next, 0);
        end

        // Stall: last rise was at the start of the final table period.
        bus.sig_in = 1'b0;
        wait_cycles(999);
        chk("stall.early_stalled", int'(bus.stalled), 0);
        chk("stall.early_locked",  int'(bus.locked),  1);
        wait_cycles(2);
        chk("stall.stalled",    int'(bus.stalled),    1);
        chk("stall.locked",     int'(bus.locked),     0);
        chk("stall.unlock_cnt", int'(bus.unlock_cnt), 3);
        run_period(25, 13);
        chk("restart.stalled",    snap_st, 0);
        chk("restart.meas_valid", snap_mv, 0);
        run_period(25, 13);
        chk("restart2.meas_valid", snap_mv, 1);
        chk("restart2.period",     snap_per, 25);
        chk("restart2.locked",     snap_lk, 0);

        // Rise lands exactly when the count reaches the timeout value.
        run_period(1023, 5);
        run_period(25, 13);
        chk("coinc.meas_valid", snap_mv, 1);
        chk("coinc.period",     snap_per, 1023);
        chk("coinc.high_time",  snap_high, 5);
        chk("coinc.stalled",    snap_st, 0);
        chk("coinc.unlock_cnt", snap_unl, 3);

        // Reset for one cycle during the low phase of a period.
        for (int i = 0; i < 25; i++) begin
            bus.sig_in = (i < 13);
            rst = (i == 18);
            @(posedge clk);
            #1;
            if (i == 18) begin
                rst = 1'b0;
                chk_all_zero("midreset");
            end
        end
        run_period(25, 13);
        chk("postreset1.meas_valid", snap_mv, 0);
        run_period(25, 13);
        chk("postreset2.meas_valid", snap_mv, 1);
        chk("postreset2.period",     snap_per, 25);
        chk("postreset2.high_time",  snap_high, 13);

        // Repeated lock / unlock to drive unlock_cnt into saturation.
        for (int k = 1; k <= 260; k++) begin
            run_period(25, 13);
            if (k == 200) chk("sat.k200", snap_unl, 199);
            if (k == 256) chk("sat.k256", snap_unl, 255);
            if (k == 260) begin
                chk("sat.k260", snap_unl, 255);
                chk("sat.k260_locked", snap_lk, 0);
            end
            run_period(25, 13);
            run_period(25, 13);
            run_period(25, 13);
            run_period(4, 2);
            if (k == 10) chk("sat.k10_locked_before_drop", snap_lk, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
